// File: rtl/chip8_blitter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_blitter_pkg
//  Description : Shared constants for the CHIP-8/SCHIP blitter. Holds the
//                command opcodes, the hires/lores coordinate masks and a
//                helper that forms a framebuffer byte address.
//  Revision    : 1.0 - initial release
// ============================================================================
package chip8_blitter_pkg;

  // Command encodings shared with the CPU; all other codes are no-ops.
  localparam logic [2:0] BLIT_OP_CLEAR     = 3'd1;
  localparam logic [2:0] BLIT_OP_SPRITE    = 3'd2;
  localparam logic [2:0] BLIT_OP_SPRITE_16 = 3'd3;

  // Pixel-column, row and byte-column masks for the two display modes.
  localparam logic [6:0] HIRES_COL_MASK  = 7'h7F;
  localparam logic [6:0] LORES_COL_MASK  = 7'h3F;
  localparam logic [5:0] HIRES_ROW_MASK  = 6'h3F;
  localparam logic [5:0] LORES_ROW_MASK  = 6'h1F;
  localparam logic [3:0] HIRES_BYTE_MASK = 4'hF;
  localparam logic [3:0] LORES_BYTE_MASK = 4'h7;

  // Byte address {row, byte-column} for sprite row `row` and pattern byte `k`.
  // Both fields wrap inside the active display rather than clipping.
  function automatic logic [9:0] fb_byte_addr(input logic [5:0] y,
                                              input logic [3:0] row,
                                              input logic [3:0] xbyte,
                                              input logic [1:0] k,
                                              input logic       hires);
    logic [5:0] r;
    logic [3:0] c;
    r = (y + {2'b00, row}) & (hires ? HIRES_ROW_MASK : LORES_ROW_MASK);
    c = (xbyte + {2'b00, k}) & (hires ? HIRES_BYTE_MASK : LORES_BYTE_MASK);
    return {r, c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_blitter_row_shift.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_blitter_row_shift  (the blit_row_shift unit)
//  Description : Combinational aligner. Places a sprite row at a sub-byte
//                pixel offset and splits it into up to three framebuffer
//                bytes (MSB = leftmost pixel).
//  Ports       : rowdata  - {first byte, second byte}; second ignored if 8-wide
//                width16  - 1 = 16-pixel row, 0 = 8-pixel row
//                shift    - pixel offset within the first byte (dest_x[2:0])
//                p0..p2   - pattern bytes, left to right
//  Revision    : 1.0 - initial release
// ============================================================================
module chip8_blitter_row_shift (
  input  logic [15:0] rowdata,
  input  logic        width16,
  input  logic [2:0]  shift,
  output logic [7:0]  p0,
  output logic [7:0]  p1,
  output logic [7:0]  p2
);

  logic [23:0] padded;
  logic [23:0] shifted;

  always_comb begin
    padded  = {rowdata[15:8], (width16 ? rowdata[7:0] : 8'h00), 8'h00};
    shifted = padded >> shift;
    p0      = shifted[23:16];
    p1      = shifted[15:8];
    p2      = shifted[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/chip8_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_blitter
//  Description : Draw engine behind the CHIP-8/SCHIP CPU. Executes one
//                clear / 8xN sprite / 16x16 sprite command at a time against
//                a byte-packed 128x64 framebuffer using read-modify-write XOR.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                hires, op, src, src_height, dest_x, dest_y, enable
//                                     - command request (enable is a level)
//                done, collision      - completion pulse, VF collision flag
//                mem_en/addr/out      - sprite source memory (1-cycle read)
//                fb_en/wr/addr/in/out - framebuffer port (1-cycle read)
//  Revision    : 1.0 - initial release
// ============================================================================
module chip8_blitter
  import chip8_blitter_pkg::*;
#(
  parameter int FB_ADDR_W  = 10,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hires,
  input  logic [2:0]            op,
  input  logic [MEM_ADDR_W-1:0] src,
  input  logic [3:0]            src_height,
  input  logic [6:0]            dest_x,
  input  logic [5:0]            dest_y,
  input  logic                  enable,
  output logic                  done,
  output logic                  collision,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_out,
  output logic                  fb_en,
  output logic                  fb_wr,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [7:0]            fb_in,
  input  logic [7:0]            fb_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH_HI, S_FETCH_LO, S_FETCH_WAIT,
    S_FB_RD, S_FB_WAIT, S_FB_WR, S_DONE
  } state_t;

  state_t                state;
  logic                  armed;
  logic                  wide;
  logic                  lat_hires;
  logic [6:0]            x_lat;
  logic [5:0]            y_lat;
  logic [3:0]            last_row;
  logic [3:0]            row;
  logic [1:0]            byte_k;
  logic [MEM_ADDR_W-1:0] src_ptr;
  logic [7:0]            row_hi;
  logic [7:0]            row_lo;

  logic [7:0] pat0, pat1, pat2, pat_k;
  logic [1:0] last_k;
  logic [9:0] addr_cur, addr_next;

  chip8_blitter_row_shift u_row_shift (
    .rowdata ({row_hi, row_lo}),
    .width16 (wide),
    .shift   (x_lat[2:0]),
    .p0      (pat0),
    .p1      (pat1),
    .p2      (pat2)
  );

  always_comb begin
    case (byte_k)
      2'd0:    pat_k = pat0;
      2'd1:    pat_k = pat1;
      default: pat_k = pat2;
    endcase
    last_k    = wide ? 2'd2 : 2'd1;
    addr_cur  = fb_byte_addr(y_lat, row, x_lat[6:3], byte_k, lat_hires);
    addr_next = fb_byte_addr(y_lat, row, x_lat[6:3], byte_k + 2'd1, lat_hires);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      fb_en     <= 1'b0;
      fb_wr     <= 1'b0;
      fb_addr   <= '0;
      fb_in     <= 8'h00;
      wide      <= 1'b0;
      lat_hires <= 1'b0;
      x_lat     <= 7'd0;
      y_lat     <= 6'd0;
      last_row  <= 4'd0;
      row       <= 4'd0;
      byte_k    <= 2'd0;
      src_ptr   <= '0;
      row_hi    <= 8'h00;
      row_lo    <= 8'h00;
    end else begin
      // A fresh request needs enable to have been seen low first.
      if (!enable) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (enable && armed) begin
            armed     <= 1'b0;
            collision <= 1'b0;
            lat_hires <= hires;
            x_lat     <= dest_x & (hires ? HIRES_COL_MASK : LORES_COL_MASK);
            y_lat     <= dest_y & (hires ? HIRES_ROW_MASK : LORES_ROW_MASK);
            wide      <= (op == BLIT_OP_SPRITE_16);
            last_row  <= (op == BLIT_OP_SPRITE_16) ? 4'hF : (src_height - 4'd1);
            row       <= 4'd0;
            byte_k    <= 2'd0;
            if (op == BLIT_OP_CLEAR) begin
              state   <= S_CLEAR;
              fb_en   <= 1'b1;
              fb_wr   <= 1'b1;
              fb_addr <= '0;
              fb_in   <= 8'h00;
            end else if ((op == BLIT_OP_SPRITE && src_height != 4'd0) ||
                         op == BLIT_OP_SPRITE_16) begin
              state    <= S_FETCH_HI;
              mem_en   <= 1'b1;
              mem_addr <= src;
              src_ptr  <= src + MEM_ADDR_W'(1);
            end else begin
              // Zero-height sprite or unknown op: finish with no memory traffic.
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          if (fb_addr == '1) begin
            state <= S_DONE;
            fb_en <= 1'b0;
            fb_wr <= 1'b0;
            done  <= 1'b1;
          end else begin
            fb_addr <= fb_addr + FB_ADDR_W'(1);
          end
        end

        S_FETCH_HI: begin
          if (wide) begin
            state    <= S_FETCH_LO;
            mem_addr <= src_ptr;
            src_ptr  <= src_ptr + MEM_ADDR_W'(1);
          end else begin
            state  <= S_FETCH_WAIT;
            mem_en <= 1'b0;
          end
        end

        // First byte is on mem_out now; second read is in flight.
        S_FETCH_LO: begin
          row_hi <= mem_out;
          mem_en <= 1'b0;
          state  <= S_FETCH_WAIT;
        end

        S_FETCH_WAIT: begin
          if (wide) begin
            row_lo <= mem_out;
          end else begin
            row_hi <= mem_out;
            row_lo <= 8'h00;
          end
          state   <= S_FB_RD;
          fb_en   <= 1'b1;
          fb_wr   <= 1'b0;
          fb_addr <= FB_ADDR_W'(addr_cur);
        end

        S_FB_RD: begin
          state <= S_FB_WAIT;
        end

        // Old byte is on fb_out: XOR in the pattern and note lit pixels cleared.
        S_FB_WAIT: begin
          fb_in     <= fb_out ^ pat_k;
          collision <= collision | (|(fb_out & pat_k));
          fb_wr     <= 1'b1;
          state     <= S_FB_WR;
        end

        S_FB_WR: begin
          fb_wr <= 1'b0;
          if (byte_k != last_k) begin
            byte_k  <= byte_k + 2'd1;
            fb_addr <= FB_ADDR_W'(addr_next);
            state   <= S_FB_RD;
          end else if (row != last_row) begin
            row      <= row + 4'd1;
            byte_k   <= 2'd0;
            fb_en    <= 1'b0;
            mem_en   <= 1'b1;
            mem_addr <= src_ptr;
            src_ptr  <= src_ptr + MEM_ADDR_W'(1);
            state    <= S_FETCH_HI;
          end else begin
            fb_en <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          done   <= 1'b0;
          mem_en <= 1'b0;
          fb_en  <= 1'b0;
          fb_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_chip8_blitter
//  Description : Directed self-checking bench for chip8_blitter with
//                behavioural 1-cycle-latency sprite memory and framebuffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_blitter;
  import chip8_blitter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, hires, enable;
  logic [2:0]  op;
  logic [11:0] src;
  logic [3:0]  src_height;
  logic [6:0]  dest_x;
  logic [5:0]  dest_y;
  logic        done, collision, mem_en, fb_en, fb_wr;
  logic [11:0] mem_addr;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_in, fb_out, mem_out;

  always #5 clk = ~clk;

  chip8_blitter #(.FB_ADDR_W(10), .MEM_ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .hires(hires), .op(op), .src(src),
    .src_height(src_height), .dest_x(dest_x), .dest_y(dest_y),
    .enable(enable), .done(done), .collision(collision),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_out(mem_out),
    .fb_en(fb_en), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_in(fb_in),
    .fb_out(fb_out)
  );

  logic [7:0] fb  [0:1023];
  logic [7:0] mem [0:4095];
  logic       fill_req = 1'b0;
  logic [7:0] fill_val = 8'h00;
  logic       lores_watch = 1'b0;
  logic [9:0] last_wr_addr = 10'h3FF;
  int cyc = 0, wr_cnt = 0, order_err = 0, nz_cnt = 0, done_cnt = 0;
  int done_cyc = 0, last_wr_cyc = 0, mem_rd_cnt = 0, lores_err = 0;

  // Memory models plus write/done logging.
  always @(posedge clk) begin
    cyc++;
    if (fill_req) begin
      for (int i = 0; i < 1024; i++) fb[i] <= fill_val;
    end else if (fb_en) begin
      if (fb_wr) begin
        fb[fb_addr] <= fb_in;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (fb_addr != last_wr_addr + 10'd1) order_err++;
        if (fb_in != 8'h00) nz_cnt++;
        if (lores_watch && (fb_addr[3] || fb_addr[9])) lores_err++;
        last_wr_addr = fb_addr;
      end
      fb_out <= fb[fb_addr];
    end
    if (mem_en) begin
      mem_out <= mem[mem_addr];
      mem_rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_vec = 0, n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    @(negedge clk);
    fill_val = v;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  // Issue one command, wait (bounded) for done, then step one cycle past it.
  task automatic run_cmd(input logic [2:0] o, input logic [11:0] s, input logic [3:0] h,
                         input logic [6:0] x, input logic [5:0] y, input logic hr,
                         input string tag);
    bit got;
    @(negedge clk);
    op = o; src = s; src_height = h; dest_x = x; dest_y = y; hires = hr; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
  endtask

  int w0, d0, o0, n0, m0;
  bit hit;

  initial begin
    reset = 1'b1; enable = 1'b0; op = 3'd0; src = 12'h000; src_height = 4'd0;
    dest_x = 7'd0; dest_y = 6'd0; hires = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_flags", {done, collision, mem_en, fb_en, fb_wr}, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fb_in", fb_in, 0);
    reset = 1'b0;

    // CLEAR over a framebuffer of 0xFF.
    fill(8'hFF);
    w0 = wr_cnt; d0 = done_cnt; o0 = order_err; n0 = nz_cnt; m0 = mem_rd_cnt;
    run_cmd(BLIT_OP_CLEAR, 12'h000, 4'd0, 7'd0, 6'd0, 1'b1, "clr");
    check("clr_writes", wr_cnt - w0, 1024);
    check("clr_order", order_err - o0, 0);
    check("clr_data", nz_cnt - n0, 0);
    check("clr_done_gap", done_cyc - last_wr_cyc, 1);
    check("clr_done_cnt", done_cnt - d0, 1);
    check("clr_mem_reads", mem_rd_cnt - m0, 0);
    check("clr_coll", collision, 0);
    check("clr_fb0", fb[0], 8'h00);
    check("clr_fb1023", fb[1023], 8'h00);

    // 8-wide sprite at an aligned column, then again to erase it.
    mem[12'h300] = 8'hF0;
    w0 = wr_cnt;
    run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd1, 7'd8, 6'd0, 1'b1, "spr1");
    check("spr1_fb1", fb[1], 8'hF0);
    check("spr1_fb2", fb[2], 8'h00);
    check("spr1_coll", collision, 0);
    check("spr1_writes", wr_cnt - w0, 2);
    run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd1, 7'd8, 6'd0, 1'b1, "spr2");
    check("spr2_fb1", fb[1], 8'h00);
    check("spr2_coll", collision, 1);

    // Zero-height sprite and an unknown op: no traffic, collision cleared.
    w0 = wr_cnt; m0 = mem_rd_cnt; d0 = done_cnt;
    run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd0, 7'd8, 6'd0, 1'b1, "h0");
    check("h0_coll", collision, 0);
    check("h0_mem_reads", mem_rd_cnt - m0, 0);
    check("h0_writes", wr_cnt - w0, 0);
    check("h0_done_cnt", done_cnt - d0, 1);
    w0 = wr_cnt; m0 = mem_rd_cnt;
    run_cmd(3'd7, 12'h300, 4'd4, 7'd0, 6'd0, 1'b1, "badop");
    check("badop_traffic", (wr_cnt - w0) + (mem_rd_cnt - m0), 0);

    // Unaligned column: 0xFF >> 3 spans two bytes.
    mem[12'h300] = 8'hFF;
    run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd1, 7'd3, 6'd2, 1'b1, "shift");
    check("shift_fb20", fb[10'h020], 8'h1F);
    check("shift_fb21", fb[10'h021], 8'hE0);
    check("shift_coll", collision, 0);

    // Hires wrap on both axes.
    mem[12'h301] = 8'hFF;
    run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd2, 7'd126, 6'd63, 1'b1, "wrap");
    check("wrap_fb1023", fb[1023], 8'h03);
    check("wrap_fb1008", fb[1008], 8'hFC);
    check("wrap_fb15", fb[15], 8'h03);
    check("wrap_fb0", fb[0], 8'hFC);

    // Lores 16x16 wrap on a cleared framebuffer.
    run_cmd(BLIT_OP_CLEAR, 12'h000, 4'd0, 7'd0, 6'd0, 1'b1, "clr2");
    for (int i = 0; i < 32; i++) mem[12'h300 + i] = 8'hFF;
    lores_watch = 1'b1;
    w0 = wr_cnt;
    run_cmd(BLIT_OP_SPRITE_16, 12'h300, 4'd0, 7'd60, 6'd30, 1'b0, "lores");
    lores_watch = 1'b0;
    check("lores_writes", wr_cnt - w0, 48);
    check("lores_outside", lores_err, 0);
    check("lores_r30c7", fb[30*16+7], 8'h0F);
    check("lores_r31c0", fb[31*16+0], 8'hFF);
    check("lores_r0c1", fb[0*16+1], 8'hF0);
    check("lores_r13c7", fb[13*16+7], 8'h0F);
    check("lores_r14c0", fb[14*16+0], 8'h00);
    check("lores_coll", collision, 0);

    // Busy: a short pulse is dropped, a held request starts on the first IDLE cycle.
    w0 = wr_cnt;
    @(negedge clk);
    op = BLIT_OP_CLEAR; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    op = BLIT_OP_SPRITE; src = 12'h300; src_height = 4'd1; dest_x = 7'd0; dest_y = 6'd0;
    hires = 1'b1; enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (done) hit = 1'b1;
      else @(negedge clk);
    end
    check("busy_clr_done", hit, 1);
    check("busy_clr_writes", wr_cnt - w0, 1024);
    @(negedge clk);
    check("busy_idle_mem_en", mem_en, 0);
    @(negedge clk);
    check("busy_accept_mem", {mem_en, mem_addr}, {1'b1, 12'h300});
    enable = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (done) hit = 1'b1;
      else @(negedge clk);
    end
    check("busy_spr_done", hit, 1);
    @(negedge clk);
    check("busy_fb0", fb[0], 8'hFF);
    check("busy_fb1", fb[1], 8'h00);

    // Reset during CLEAR, right as the 100th write (address 99) lands.
    fill(8'hA5);
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    op = BLIT_OP_CLEAR; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (fb_wr && fb_addr == 10'd99) hit = 1'b1;
      else @(negedge clk);
    end
    check("rstmid_reach99", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_outs", {done, fb_en, fb_wr, mem_en}, 0);
    check("rstmid_fb_addr", fb_addr, 0);
    repeat (5) @(negedge clk);
    check("rstmid_done_cnt", done_cnt - d0, 0);
    check("rstmid_writes", wr_cnt - w0, 100);
    check("rstmid_fb99", fb[99], 8'h00);
    check("rstmid_fb100", fb[100], 8'hA5);
    check("rstmid_fb1023", fb[1023], 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
